// File: rtl/spi_flash_read_bridge_pkg.sv
// Shared definitions for the SPI flash read bridge.
//   - SPI master register offsets (TXDATA/RXDATA/STATUS/CTRL)
//   - flash READ opcode
//   - bridge FSM state enumeration
//   - cmd_byte(): byte k of the 8-byte READ exchange for a given address
package spi_flash_read_bridge_pkg;

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_RXDATA = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_CTRL   = 4'hC;

  localparam logic [7:0] OP_READ = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_ON,
    ST_TX,
    ST_POLL,
    ST_RX,
    ST_CS_OFF,
    ST_DONE,
    ST_FAIL
  } state_e;

  // Opcode, three address bytes (word aligned), then four dummy bytes
  // that clock the data out of the flash.
  function automatic logic [7:0] cmd_byte(input logic [2:0] k, input logic [23:0] a);
    logic [7:0] b;
    case (k)
      3'd0:    b = OP_READ;
      3'd1:    b = a[23:16];
      3'd2:    b = a[15:8];
      3'd3:    b = {a[7:2], 2'b00};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_read_bridge_spi_wb_access.sv
// spi_wb_access: single-access Wishbone classic master sequencer.
//   start_i/we_i/adr_i/wdat_i : request, sampled when no access is in flight
//   done_o/err_o/rdat_o       : termination seen this cycle (combinational
//                               from M_ACK_I/M_ERR_I), read data passthrough
//   M_*                       : registered bus controls, held until the
//                               cycle ACK or ERR is sampled, then dropped
//                               for at least one cycle.
module spi_wb_access (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [3:0]  adr_i,
  input  logic [31:0] wdat_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdat_o,
  output logic [3:0]  M_ADR_O,
  output logic [31:0] M_DAT_O,
  output logic [3:0]  M_SEL_O,
  output logic        M_WE_O,
  output logic        M_CYC_O,
  output logic        M_STB_O,
  input  logic [31:0] M_DAT_I,
  input  logic        M_ACK_I,
  input  logic        M_ERR_I
);

  logic        cyc_q;
  logic        we_q;
  logic [3:0]  adr_q;
  logic [31:0] dat_q;

  // A start seen while a cycle is open (including its ack cycle) is ignored,
  // which guarantees the idle gap between back-to-back accesses.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (cyc_q) begin
      if (M_ACK_I || M_ERR_I) begin
        cyc_q <= 1'b0;
        we_q  <= 1'b0;
      end
    end else if (start_i) begin
      cyc_q <= 1'b1;
      we_q  <= we_i;
      adr_q <= adr_i;
      dat_q <= wdat_i;
    end
  end

  assign done_o  = cyc_q & (M_ACK_I | M_ERR_I);
  assign err_o   = cyc_q & M_ERR_I;
  assign rdat_o  = M_DAT_I;

  assign M_CYC_O = cyc_q;
  assign M_STB_O = cyc_q;
  assign M_WE_O  = we_q;
  assign M_ADR_O = adr_q;
  assign M_DAT_O = dat_q;
  assign M_SEL_O = 4'hF;

endmodule

// File: rtl/spi_flash_read_bridge.sv
// spi_flash_read_bridge: maps serial NOR flash into CPU address space.
// Each 32-bit CPU read becomes a READ (0x03) command driven through the SPI
// master's register interface; the four data bytes come back little-endian.
//   S_* : CPU-side Wishbone classic slave (reads only, writes get S_ERR_O)
//   M_* : Wishbone master onto the SPI master's register port
// Parameters: POLL_MAX busy polls per byte before abort; SPI_BASE is added
// to every register offset on M_ADR_O.
module spi_flash_read_bridge
  import spi_flash_read_bridge_pkg::*;
#(
  parameter int         POLL_MAX = 1024,
  parameter logic [3:0] SPI_BASE = 4'h0
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [23:0] S_ADR_I,
  input  logic [31:0] S_DAT_I,
  input  logic [3:0]  S_SEL_I,
  input  logic        S_WE_I,
  input  logic        S_CYC_I,
  input  logic        S_STB_I,
  output logic [31:0] S_DAT_O,
  output logic        S_ACK_O,
  output logic        S_ERR_O,
  output logic [3:0]  M_ADR_O,
  output logic [31:0] M_DAT_O,
  output logic [3:0]  M_SEL_O,
  output logic        M_WE_O,
  output logic        M_CYC_O,
  output logic        M_STB_O,
  input  logic [31:0] M_DAT_I,
  input  logic        M_ACK_I,
  input  logic        M_ERR_I
);

  localparam int PW = $clog2(POLL_MAX + 1);

  state_e      state_q, state_d;

  logic        acc_start, acc_we;
  logic [3:0]  acc_adr;
  logic [31:0] acc_wdat;
  logic        acc_done, acc_err;
  logic [31:0] acc_rdat;

  logic [23:0] addr_q;
  logic [2:0]  k_q;
  logic [PW-1:0] poll_q;
  logic        fail_q, abandon_q;
  logic [31:0] dat_q;
  logic        ack_q, err_q;

  logic        accept, busy, timeout, in_seq, abort;

  // Hold off a new accept while our own ack/err pulse is on the bus: the CPU
  // still has STB up in that cycle.
  assign accept  = (state_q == ST_IDLE) & S_CYC_I & S_STB_I & ~ack_q & ~err_q;
  assign busy    = acc_rdat[0];
  assign timeout = (poll_q == PW'(POLL_MAX - 1));
  assign in_seq  = (state_q == ST_CS_ON) | (state_q == ST_TX) |
                   (state_q == ST_POLL)  | (state_q == ST_RX);
  assign abort   = acc_done & in_seq &
                   (acc_err | ((state_q == ST_POLL) & busy & timeout));

  logic unused_ok;
  assign unused_ok = ^{S_DAT_I, S_SEL_I, S_ADR_I[1:0], acc_rdat[31:8]};

  spi_wb_access u_acc (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .start_i (acc_start),
    .we_i    (acc_we),
    .adr_i   (acc_adr),
    .wdat_i  (acc_wdat),
    .done_o  (acc_done),
    .err_o   (acc_err),
    .rdat_o  (acc_rdat),
    .M_ADR_O (M_ADR_O),
    .M_DAT_O (M_DAT_O),
    .M_SEL_O (M_SEL_O),
    .M_WE_O  (M_WE_O),
    .M_CYC_O (M_CYC_O),
    .M_STB_O (M_STB_O),
    .M_DAT_I (M_DAT_I),
    .M_ACK_I (M_ACK_I),
    .M_ERR_I (M_ERR_I)
  );

  // State register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept && !S_WE_I) state_d = ST_CS_ON;
      ST_CS_ON:  if (acc_done) state_d = abort ? ST_CS_OFF : ST_TX;
      ST_TX:     if (acc_done) state_d = abort ? ST_CS_OFF : ST_POLL;
      ST_POLL:   if (acc_done) begin
                   if (abort)     state_d = ST_CS_OFF;
                   else if (busy) state_d = ST_POLL;
                   else           state_d = ST_RX;
                 end
      ST_RX:     if (acc_done) state_d = (abort || k_q == 3'd7) ? ST_CS_OFF : ST_TX;
      ST_CS_OFF: if (acc_done) state_d = (acc_err || fail_q) ? ST_FAIL : ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      ST_FAIL:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: which register access the sequencer should run
  always_comb begin
    acc_start = 1'b0;
    acc_we    = 1'b0;
    acc_adr   = SPI_BASE + REG_TXDATA;
    acc_wdat  = '0;
    case (state_q)
      ST_CS_ON: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_adr   = SPI_BASE + REG_CTRL;
        acc_wdat  = 32'd1;
      end
      ST_TX: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_adr   = SPI_BASE + REG_TXDATA;
        acc_wdat  = {24'h0, cmd_byte(k_q, addr_q)};
      end
      ST_POLL: begin
        acc_start = 1'b1;
        acc_adr   = SPI_BASE + REG_STATUS;
      end
      ST_RX: begin
        acc_start = 1'b1;
        acc_adr   = SPI_BASE + REG_RXDATA;
      end
      ST_CS_OFF: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_adr   = SPI_BASE + REG_CTRL;
        acc_wdat  = 32'd0;
      end
      default: ;
    endcase
  end

  // Sequence bookkeeping, data capture and CPU termination pulses
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      addr_q    <= '0;
      k_q       <= '0;
      poll_q    <= '0;
      fail_q    <= 1'b0;
      abandon_q <= 1'b0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= (state_q == ST_DONE) & ~abandon_q & S_CYC_I;
      err_q <= ((state_q == ST_FAIL) & ~abandon_q & S_CYC_I) | (accept & S_WE_I);

      if (accept && !S_WE_I) begin
        addr_q    <= S_ADR_I;
        k_q       <= '0;
        poll_q    <= '0;
        fail_q    <= 1'b0;
        abandon_q <= 1'b0;
      end

      // CPU walked away: finish the flash command cleanly but stay silent.
      if (state_q != ST_IDLE && !S_CYC_I) abandon_q <= 1'b1;

      if (acc_done && !acc_err) begin
        case (state_q)
          ST_TX:   poll_q <= '0;
          ST_POLL: if (busy) poll_q <= poll_q + PW'(1);
          ST_RX: begin
            if (k_q[2]) dat_q[{k_q[1:0], 3'b000} +: 8] <= acc_rdat[7:0];
            k_q <= k_q + 3'd1;
          end
          default: ;
        endcase
      end

      if (abort) fail_q <= 1'b1;
    end
  end

  assign S_DAT_O = dat_q;
  assign S_ACK_O = ack_q;
  assign S_ERR_O = err_q;

endmodule
